strided_addr_gen: RTL
=====================

Name: strided_addr_gen

Overview:
Parametrised vector load/store address generator for the AVA core LSU. It accepts a base address, byte stride (signed, may be negative or zero), vector length and element width. It then issues a stream of bus-word-aligned beats, each with address, byte enables, first-element index and element count. Compared with the single-width generator, it adds bus width as a parameter, 64-bit elements, negative strides, a true valid/ready handshake with no bubble between beats, an abort input and misalignment detection.

Parameters:
BUS_BYTES, 4, bytes per bus beat; 4 or 8.
VL_W, 5, width of the vector length and element index fields.
ADDR_W, 32, address width.

Ports:
clk_i  input  1  clock, rising edge
n_rst_i  input  1  asynchronous active-low reset
base_addr_i  input  ADDR_W  address of element 0; sampled on accepted start
stride_i  input  ADDR_W  signed byte stride; sampled on accepted start
vl_i  input  VL_W  element count; sampled on accepted start
vsew_i  input  2  element size = 1<<vsew_i bytes; sampled on accepted start
au_start_i  input  1  start request; honoured only while au_ready_o=1
au_abort_i  input  1  abandon the current operation
au_next_i  input  1  consumer accepts the current beat
au_ready_o  output  1  idle, can accept a start
au_valid_o  output  1  beat outputs are valid
au_addr_o  output  ADDR_W  beat address, aligned to BUS_BYTES
au_be_o  output  BUS_BYTES  byte enables of the beat
vd_offset_o  output  VL_W  index of the first element in the beat
au_count_o  output  VL_W  number of elements in the beat
au_final_o  output  1  current beat is the last one
au_error_o  output  1  one-cycle pulse on a rejected start

Behaviour:
- One clock, clk_i. Reset is asynchronous on n_rst_i, active low.
- Reset values: state IDLE; au_ready_o=1; all other outputs 0; internal registers 0.
- States:
  - IDLE: au_ready_o=1. An accepted start with legal inputs goes to ISSUE. An accepted start with vl_i=0 stays in IDLE, issues no beat and pulses au_error_o=0 (no-op).
  - ISSUE: au_valid_o=1. The next beat is computed from the current element address and the remaining element count.
- Start rejection:
  - Condition: vsew_i > log2(BUS_BYTES), or base_addr_i not aligned to the element size, or stride_i not a multiple of the element size (unless stride=0).
  - Response: au_error_o=1 for one cycle, state stays IDLE, no beats.
- Latency: start accepted in cycle N gives the first beat valid in cycle N+1.
- Handshake:
  - A beat is transferred when au_valid_o and au_next_i are both high.
  - While au_next_i is low, all beat outputs stay stable.
  - After a transfer, the next beat is valid in the following cycle (back-to-back).
  - au_next_i has no effect while au_valid_o=0.
- Beat packing (stride != 0):
  - Candidates k=0..BUS_BYTES-1 have address cur+k*stride.
  - The beat takes the longest prefix where k < remaining and the candidate's word address (addr with its low log2(BUS_BYTES) bits cleared) equals that of k=0.
  - au_be_o is the OR of each packed element's byte-lane mask.
  - au_count_o is the prefix length.
  - After the transfer: cur += count*stride, vd_offset += count, remaining -= count.
- Stride zero: exactly one beat. au_be_o covers the single element, au_count_o=vl, au_final_o=1.
- au_final_o=1 exactly when count == remaining. It is combinational with the beat and asserted alongside au_valid_o. Its transfer returns the block to IDLE in the next cycle.
- Arithmetic: addresses wrap modulo 2^ADDR_W; negative strides use two's complement.
- Abort:
  - au_abort_i in any state goes to IDLE in the next cycle. A transfer in the same cycle is still counted as completed.
  - Abort has priority over start.
- au_start_i while in ISSUE is ignored.
- Asynchronous reset mid-operation returns every output to its reset value immediately.

Decomposition:
- Shared package ava_lsu_pkg holds:
  - typedef ag_state_t {IDLE, ISSUE};
  - vsew encoding constants (SEW8..SEW64);
  - function sew_bytes(vsew).
- Combinational sub-module beat_packer: inputs are the current address, stride, vsew and remaining count; outputs are addr, be and count. Its parameters are passed through.
- The top level holds the FSM, the element registers and the handshake.

Test Plan:
- BUS_BYTES=4, vsew=0, stride=1, base=0x1002, vl=10 -> beats {0x1000, be 1100, off0, cnt2}, {0x1004, be 1111, off2, cnt4}, {0x1008, be 1111, off6, cnt4, final}.
- vsew=1, stride=6, base=0x2000, vl=3 -> {0x2000, be 0011, cnt1}, {0x2004, be 1100, off1}, {0x200C, be 0011, off2, final}.
- vsew=2, stride=-4, base=0x3008, vl=3 -> addresses 0x3008, 0x3004, 0x3000, each be 1111, final on the third beat.
- vsew=0, stride=0, base=0x4001, vl=7 -> single beat {0x4000, be 0010, cnt7, final}; au_ready_o=1 the next cycle.
- Backpressure: hold au_next_i low for 3 cycles mid-stream -> outputs stable; then assert au_abort_i -> au_valid_o=0 and au_ready_o=1 the next cycle.
- BUS_BYTES=4: vsew=2, base=0x5002 -> au_error_o pulse and no au_valid_o. Also vsew=3 -> au_error_o. BUS_BYTES=8, vsew=3, stride=8, vl=2 -> two beats with be 0xFF.

Source files
------------

// File: rtl/ava_lsu_pkg.sv
// Shared definitions for the AVA LSU address-generation blocks.
//   ag_state_t : address generator FSM states
//   SEW8..SEW64: element-width encodings (element bytes = 1 << vsew)
//   sew_bytes  : element size in bytes for a vsew encoding
package ava_lsu_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } ag_state_t;

    localparam logic [1:0] SEW8  = 2'd0;
    localparam logic [1:0] SEW16 = 2'd1;
    localparam logic [1:0] SEW32 = 2'd2;
    localparam logic [1:0] SEW64 = 2'd3;

    function automatic logic [3:0] sew_bytes(input logic [1:0] vsew);
        return 4'd1 << vsew;
    endfunction

endpackage

// File: rtl/beat_packer.sv
// Combinational beat packer.
// From the current element address, stride, element width and remaining
// element count, works out which leading elements fall into the same
// bus word and produces that beat's aligned address, byte enables and
// element count.
//   cur_addr  : address of the next element to issue
//   stride    : signed byte stride (two's complement)
//   vsew      : element width encoding
//   remaining : elements still to issue
//   addr      : bus-word-aligned beat address
//   be        : byte-lane enables of all packed elements
//   count     : number of elements packed into the beat
module beat_packer
    import ava_lsu_pkg::*;
#(
    parameter int BUS_BYTES = 4,
    parameter int VL_W      = 5,
    parameter int ADDR_W    = 32
) (
    input  logic [ADDR_W-1:0]    cur_addr,
    input  logic [ADDR_W-1:0]    stride,
    input  logic [1:0]           vsew,
    input  logic [VL_W-1:0]      remaining,
    output logic [ADDR_W-1:0]    addr,
    output logic [BUS_BYTES-1:0] be,
    output logic [VL_W-1:0]      count
);

    localparam int LB = $clog2(BUS_BYTES);

    logic [BUS_BYTES-1:0] sew_mask;
    logic [ADDR_W-1:0]    cand;
    logic                 run;

    // Lane mask of one element sitting at lane 0.
    always_comb begin
        sew_mask = '0;
        for (int i = 0; i < BUS_BYTES; i++) begin
            sew_mask[i] = (i < int'(sew_bytes(vsew)));
        end
    end

    always_comb begin
        addr  = {cur_addr[ADDR_W-1:LB], {LB{1'b0}}};
        be    = '0;
        count = '0;
        cand  = cur_addr;
        run   = 1'b1;
        if (stride == '0) begin
            // Every element hits the same bytes: one beat carries them all.
            be    = sew_mask << cur_addr[LB-1:0];
            count = remaining;
        end else begin
            // Take the longest prefix of candidates that stay in word 0;
            // once one leaves, later ones are not packed even if they return.
            for (int k = 0; k < BUS_BYTES; k++) begin
                if (run && (k < int'(remaining)) &&
                    (cand[ADDR_W-1:LB] == cur_addr[ADDR_W-1:LB])) begin
                    be    = be | (sew_mask << cand[LB-1:0]);
                    count = count + VL_W'(1);
                end else begin
                    run = 1'b0;
                end
                cand = cand + stride;
            end
        end
    end

endmodule

// File: rtl/strided_addr_gen.sv
// Strided vector load/store address generator.
// Accepts a base address, signed byte stride, vector length and element
// width, then streams bus-word-aligned beats over a valid/next handshake
// with no bubble between beats. Illegal starts pulse au_error_o.
//   clk_i, n_rst_i  : clock, asynchronous active-low reset
//   base_addr_i, stride_i, vl_i, vsew_i : operation, sampled on start
//   au_start_i      : start request, honoured while au_ready_o=1
//   au_abort_i      : drop the current operation (priority over start)
//   au_next_i       : consumer accepts the current beat
//   au_ready_o      : idle
//   au_valid_o      : beat outputs valid
//   au_addr_o, au_be_o, vd_offset_o, au_count_o, au_final_o : beat
//   au_error_o      : one-cycle pulse after a rejected start
module strided_addr_gen
    import ava_lsu_pkg::*;
#(
    parameter int BUS_BYTES = 4,
    parameter int VL_W      = 5,
    parameter int ADDR_W    = 32
) (
    input  logic                 clk_i,
    input  logic                 n_rst_i,
    input  logic [ADDR_W-1:0]    base_addr_i,
    input  logic [ADDR_W-1:0]    stride_i,
    input  logic [VL_W-1:0]      vl_i,
    input  logic [1:0]           vsew_i,
    input  logic                 au_start_i,
    input  logic                 au_abort_i,
    input  logic                 au_next_i,
    output logic                 au_ready_o,
    output logic                 au_valid_o,
    output logic [ADDR_W-1:0]    au_addr_o,
    output logic [BUS_BYTES-1:0] au_be_o,
    output logic [VL_W-1:0]      vd_offset_o,
    output logic [VL_W-1:0]      au_count_o,
    output logic                 au_final_o,
    output logic                 au_error_o
);

    localparam int LB = $clog2(BUS_BYTES);

    ag_state_t         state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] stride;
    logic [1:0]        vsew;
    logic [VL_W-1:0]   remaining;
    logic [VL_W-1:0]   offset;
    logic              error;

    logic [ADDR_W-1:0]    pk_addr;
    logic [BUS_BYTES-1:0] pk_be;
    logic [VL_W-1:0]      pk_count;

    logic [ADDR_W-1:0] elem_mask;
    logic              start_bad;
    logic              issuing;
    logic              final_beat;

    beat_packer #(
        .BUS_BYTES (BUS_BYTES),
        .VL_W      (VL_W),
        .ADDR_W    (ADDR_W)
    ) u_packer (
        .cur_addr  (cur_addr),
        .stride    (stride),
        .vsew      (vsew),
        .remaining (remaining),
        .addr      (pk_addr),
        .be        (pk_be),
        .count     (pk_count)
    );

    // A zero stride has no low bits set, so it always passes the
    // stride-alignment test without a special case.
    assign elem_mask  = ADDR_W'(sew_bytes(vsew_i)) - ADDR_W'(1);
    assign start_bad  = (int'(vsew_i) > LB) ||
                        ((base_addr_i & elem_mask) != '0) ||
                        ((stride_i & elem_mask) != '0);

    assign issuing    = (state == ISSUE);
    assign final_beat = issuing && (pk_count == remaining);

    // Beat fields are forced to zero outside ISSUE so idle and reset
    // values are clean regardless of stale element registers.
    assign au_ready_o  = (state == IDLE);
    assign au_valid_o  = issuing;
    assign au_addr_o   = issuing ? pk_addr  : '0;
    assign au_be_o     = issuing ? pk_be    : '0;
    assign vd_offset_o = issuing ? offset   : '0;
    assign au_count_o  = issuing ? pk_count : '0;
    assign au_final_o  = final_beat;
    assign au_error_o  = error;

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state     <= IDLE;
            cur_addr  <= '0;
            stride    <= '0;
            vsew      <= '0;
            remaining <= '0;
            offset    <= '0;
            error     <= 1'b0;
        end else begin
            error <= 1'b0;
            if (au_abort_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (au_start_i) begin
                            if (start_bad) begin
                                error <= 1'b1;
                            end else if (vl_i != '0) begin
                                cur_addr  <= base_addr_i;
                                stride    <= stride_i;
                                vsew      <= vsew_i;
                                remaining <= vl_i;
                                offset    <= '0;
                                state     <= ISSUE;
                            end
                        end
                    end
                    ISSUE: begin
                        if (au_next_i) begin
                            if (final_beat) begin
                                state <= IDLE;
                            end else begin
                                cur_addr  <= cur_addr + stride * ADDR_W'(pk_count);
                                offset    <= offset + pk_count;
                                remaining <= remaining - pk_count;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
